// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin (or fixed-priority with CDB_FIXED_PRIO_EN) grant of one finished result per cycle,
// broadcast one cycle after the grant; in_stall blocks new grants while an already registered broadcast completes.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ICC_W  = 4,
  parameter logic [TAG_W-1:0] INVALID_TAG = 5'b11111,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_req,
  input  logic [N_REQ*TAG_W-1:0]  in_req_tag,
  input  logic [N_REQ*DATA_W-1:0] in_req_val,
  input  logic [N_REQ*ICC_W-1:0]  in_req_icc,
  input  logic                    in_stall,
  output logic [N_REQ-1:0]        out_grant,
  output logic                    out_CDB_broadcast,
  output logic [TAG_W-1:0]        out_CDB_tag,
  output logic [DATA_W-1:0]       out_CDB_val,
  output logic [ICC_W-1:0]        out_CDB_icc,
  output logic [CNT_W-1:0]        out_bcast_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic IDLE  = 1'b0;
  localparam logic BCAST = 1'b1;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  win;
  logic              found;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_val;
  logic [ICC_W-1:0]  sel_icc;
  logic              bcast_next;
  int                idx;

  always_comb begin
    out_grant = '0;
    win       = '0;
    found     = 1'b0;
    idx       = 0;
    if (!rst && !in_stall) begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = (int'(ptr) + i) % N_REQ;
        if (!found && in_req[idx]) begin
          found          = 1'b1;
          out_grant[idx] = 1'b1;
          win            = PTR_W'(idx);
        end
      end
    end
  end

  assign sel_tag    = in_req_tag[win*TAG_W +: TAG_W];
  assign sel_val    = in_req_val[win*DATA_W +: DATA_W];
  assign sel_icc    = in_req_icc[win*ICC_W +: ICC_W];
  assign bcast_next = (found && (sel_tag != INVALID_TAG)) ? BCAST : IDLE;

`ifdef CDB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

  // Counter steps on the edge that launches a broadcast, so it already
  // includes the broadcast that is on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_CDB_broadcast <= IDLE;
      out_CDB_tag       <= INVALID_TAG;
      out_CDB_val       <= '0;
      out_CDB_icc       <= '0;
      out_bcast_count   <= '0;
    end else begin
      out_CDB_broadcast <= bcast_next;
      if (bcast_next == BCAST) begin
        out_CDB_tag     <= sel_tag;
        out_CDB_val     <= sel_val;
        out_CDB_icc     <= sel_icc;
        out_bcast_count <= out_bcast_count + 1'b1;
      end
    end
  end

endmodule
